// File: rtl/dac_pkg.sv
// ============================================================================
// dac_pkg: shared types and constants for the serial DAC transmit path.
// Revision: 1.0
// ============================================================================
`default_nettype none

package dac_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    LATCH = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int         FRAME_BITS   = 16;
  localparam int         ADC_CODE_MAX = 255;
  localparam int         DAC_CODE_MAX = 4095;
  localparam logic [3:0] DEFAULT_CMD  = 4'b0011;

endpackage

`default_nettype wire

// File: rtl/dac_code_scaler.sv
// ============================================================================
// dac_code_scaler: combinational 8-bit to 12-bit full-scale code rescale.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dac_code_scaler
  import dac_pkg::*;
(
  input  logic [7:0]  in_code,
  output logic [11:0] dac_code
);

  logic [19:0] product;

  // Truncating divide keeps both endpoints exact: 0->0, 255->4095.
  always_comb begin
    product  = 20'(in_code) * 20'(DAC_CODE_MAX);
    dac_code = 12'(product / 20'(ADC_CODE_MAX));
  end

endmodule

`default_nettype wire

// File: rtl/dac_serial_tx.sv
// ============================================================================
// dac_serial_tx: rescales an 8-bit pressure code and sends it as a 16-bit
// SPI mode-0 frame; optional LDAC strobe enabled by macro DAC_LDAC_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dac_serial_tx
  import dac_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter logic [3:0]  CMD     = DEFAULT_CMD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_code,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       mosi,
  output logic       cs_n,
  output logic       ldac_n
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] shreg_q, shreg_d;
  logic        in_ready_q, in_ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        cs_n_q, cs_n_d;
  logic        ldac_n_q, ldac_n_d;
  logic [11:0] dac_code;
  logic        div_tc;

  dac_code_scaler u_scaler (
    .in_code  (in_code),
    .dac_code (dac_code)
  );

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    cs_n_d   = cs_n_q;
    ldac_n_d = 1'b1;
    done_d   = 1'b0;
    div_tc   = (div_q == DIV_LAST);

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = LOAD;
          shreg_d = {CMD, dac_code};
        end
      end

      LOAD: begin
        state_d = SHIFT;
        cs_n_d  = 1'b0;
        sclk_d  = 1'b0;
        mosi_d  = shreg_q[15];
        div_d   = '0;
        bit_d   = '0;
      end

      SHIFT: begin
        div_d = div_tc ? 8'd0 : div_q + 8'd1;
        if (div_tc) begin
          sclk_d = ~sclk_q;
          // Falling toggle: advance to the next bit, or close the frame.
          if (sclk_q) begin
            if (bit_q == BIT_LAST) begin
              cs_n_d = 1'b1;
              mosi_d = 1'b0;
`ifdef DAC_LDAC_EN
              state_d  = LATCH;
              ldac_n_d = 1'b0;
`else
              state_d  = DONE;
              done_d   = 1'b1;
`endif
            end else begin
              shreg_d = {shreg_q[14:0], 1'b0};
              mosi_d  = shreg_q[14];
              bit_d   = bit_q + 4'd1;
            end
          end
        end
      end

      LATCH: begin
`ifdef DAC_LDAC_EN
        div_d = div_tc ? 8'd0 : div_q + 8'd1;
        if (div_tc) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          ldac_n_d = 1'b0;
        end
`else
        state_d = DONE;
        done_d  = 1'b1;
`endif
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d     = (state_d != IDLE);
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      ldac_n_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      ldac_n_q   <= ldac_n_d;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;
  assign ldac_n   = ldac_n_q;

endmodule

`default_nettype wire
